// File: rtl/bram_frame_streamer.sv
// Reads one circular sample BRAM from head, converts to signed and streams it zero-padded to (2^ADDR_W)<<pad_log2 beats.
// rd_en 1 cycle after start, first tvalid RD_LAT+2 after start; credit-limited reads keep tready stalls lossless.
module bram_frame_streamer #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 14,
  parameter int OUT_W      = 16,
  parameter int PAD_MAX    = 2,
  parameter int RD_LAT     = 1,
  parameter int OFFSET_BIN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   head,
  output logic [ADDR_W-1:0]   addr,
  output logic                rd_en,
  input  logic [DATA_W-1:0]   data,
  input  logic                start,
  input  logic [1:0]          pad_log2,
  input  logic                last_missing,
  output logic [2*OUT_W-1:0]  frame_tdata,
  output logic                frame_tvalid,
  input  logic                frame_tready,
  output logic                frame_tlast,
  output logic                busy,
  output logic                start_dropped,
  output logic [15:0]         frames_sent
);
  localparam int D     = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + PAD_MAX;
  localparam int DEPTH = RD_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SLOTS = 1 << PTR_W;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OUT_W-1:0] SIGN_FLIP = (OFFSET_BIN != 0) ? (OUT_W'(1) << (OUT_W - 1)) : '0;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_start_dropped;
  logic [15:0]       r_frames_sent;
  logic [1:0]        r_pad;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_iss_cnt;
  logic              r_iss_done;
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [RD_LAT-1:0] r_pipe_zero;
  logic [RD_LAT-1:0] r_pipe_last;
  logic [OUT_W-1:0]  r_fifo_real [SLOTS];
  logic [SLOTS-1:0]  r_fifo_last;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_idx;
  logic [OCC_W-1:0]  r_occ;

  logic              w_credit;
  logic              w_issue;
  logic              w_is_pad;
  logic              w_is_last;
  logic              w_wr;
  logic              w_pop;
  logic              w_done;
  logic [CNT_W-1:0]  w_last_idx;
  logic [OUT_W-1:0]  w_wr_real;
  logic [1:0]        w_pad_clamped;

  // Every beat already in the tag pipeline is guaranteed a FIFO slot.
  assign w_credit      = (32'(r_occ) + 32'($countones(r_pipe_vld))) < 32'(DEPTH);
  assign w_issue       = (r_state == S_SEND) && !r_iss_done && w_credit;
  assign w_is_pad      = 32'(r_iss_cnt) >= 32'(D);
  assign w_last_idx    = CNT_W'((D << r_pad) - 1);
  assign w_is_last     = (r_iss_cnt == w_last_idx);
  assign w_pad_clamped = (pad_log2 > 2'(PAD_MAX)) ? 2'(PAD_MAX) : pad_log2;
  assign w_wr          = r_pipe_vld[RD_LAT-1];
  assign w_wr_real     = r_pipe_zero[RD_LAT-1] ? '0 : ((OUT_W'(data) << (OUT_W - DATA_W)) ^ SIGN_FLIP);
  assign w_pop         = frame_tvalid && frame_tready;
  assign w_done        = w_pop && frame_tlast;

  assign addr          = r_rd_ptr;
  assign rd_en         = w_issue && !w_is_pad;
  assign frame_tvalid  = (r_occ != '0);
  assign frame_tdata   = {{OUT_W{1'b0}}, r_fifo_real[r_rd_idx]};
  assign frame_tlast   = frame_tvalid && r_fifo_last[r_rd_idx];
  assign busy          = r_busy;
  assign start_dropped = r_start_dropped;
  assign frames_sent   = r_frames_sent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_busy          <= 1'b0;
      r_start_dropped <= 1'b0;
      r_frames_sent   <= '0;
      r_pad           <= '0;
      r_rd_ptr        <= '0;
      r_iss_cnt       <= '0;
      r_iss_done      <= 1'b0;
      r_pipe_vld      <= '0;
      r_pipe_zero     <= '0;
      r_pipe_last     <= '0;
      r_fifo_last     <= '0;
      r_wr_ptr        <= '0;
      r_rd_idx        <= '0;
      r_occ           <= '0;
      for (int i = 0; i < SLOTS; i++) r_fifo_real[i] <= '0;
    end else begin
      r_start_dropped <= start && (r_state == S_SEND);

      r_pipe_vld[0]  <= w_issue;
      r_pipe_zero[0] <= w_is_pad;
      r_pipe_last[0] <= w_is_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_zero[i] <= r_pipe_zero[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end

      if (w_wr) begin
        r_fifo_real[r_wr_ptr] <= w_wr_real;
        r_fifo_last[r_wr_ptr] <= r_pipe_last[RD_LAT-1];
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_idx <= (r_rd_idx == PTR_W'(DEPTH - 1)) ? '0 : r_rd_idx + PTR_W'(1);
      r_occ <= r_occ + OCC_W'(w_wr) - OCC_W'(w_pop);

      if (w_issue) begin
        r_iss_cnt <= r_iss_cnt + CNT_W'(1);
        if (w_is_last) r_iss_done <= 1'b1;
        if (!w_is_pad) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end

      if (w_done) r_frames_sent <= r_frames_sent + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_SEND;
            r_busy     <= 1'b1;
            r_rd_ptr   <= head;
            r_pad      <= w_pad_clamped;
            r_iss_cnt  <= '0;
            r_iss_done <= 1'b0;
          end
        end
        default: begin
          if (w_done || last_missing) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          // Abort drops queued beats and any BRAM reads still in flight.
          if (last_missing) begin
            r_pipe_vld <= '0;
            r_occ      <= '0;
            r_wr_ptr   <= '0;
            r_rd_idx   <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bram_frame_streamer.sv
// Directed bench: two streamers (D=16, RD_LAT=1 and RD_LAT=3) each reading a BRAM model holding BRAM[i]=i.
module tb_bram_frame_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  head;
  logic [1:0]  pad_log2;
  logic        last_missing, tready, start_a, start_b;
  logic [3:0]  a_addr, b_addr;
  logic        a_rd_en, b_rd_en;
  logic [13:0] a_data, b_data, b_q0, b_q1, b_q2;
  logic [31:0] a_tdata, b_tdata;
  logic        a_tvalid, b_tvalid, a_tlast, b_tlast, a_busy, b_busy, a_drop, b_drop;
  logic [15:0] a_frames, b_frames;

  int n_cmp = 0;
  int n_bad = 0;
  logic sel_b = 1'b0;
  logic m_vld, m_last;
  logic [31:0] m_dat;

  bram_frame_streamer #(.ADDR_W(4), .DATA_W(14), .OUT_W(16), .PAD_MAX(2), .RD_LAT(1), .OFFSET_BIN(1)) u_a (
    .clk(clk), .rst(rst), .head(head), .addr(a_addr), .rd_en(a_rd_en), .data(a_data),
    .start(start_a), .pad_log2(pad_log2), .last_missing(last_missing),
    .frame_tdata(a_tdata), .frame_tvalid(a_tvalid), .frame_tready(tready), .frame_tlast(a_tlast),
    .busy(a_busy), .start_dropped(a_drop), .frames_sent(a_frames));

  bram_frame_streamer #(.ADDR_W(4), .DATA_W(14), .OUT_W(16), .PAD_MAX(2), .RD_LAT(3), .OFFSET_BIN(1)) u_b (
    .clk(clk), .rst(rst), .head(head), .addr(b_addr), .rd_en(b_rd_en), .data(b_data),
    .start(start_b), .pad_log2(pad_log2), .last_missing(last_missing),
    .frame_tdata(b_tdata), .frame_tvalid(b_tvalid), .frame_tready(tready), .frame_tlast(b_tlast),
    .busy(b_busy), .start_dropped(b_drop), .frames_sent(b_frames));

  // BRAM[i] = i; non-read cycles return a junk pattern that must never reach the stream.
  always @(posedge clk) begin
    a_data <= a_rd_en ? {10'd0, a_addr} : 14'h2AAA;
    b_q0   <= b_rd_en ? {10'd0, b_addr} : 14'h2AAA;
    b_q1   <= b_q0;
    b_q2   <= b_q1;
  end
  assign b_data = b_q2;

  assign m_vld  = sel_b ? b_tvalid : a_tvalid;
  assign m_last = sel_b ? b_tlast  : a_tlast;
  assign m_dat  = sel_b ? b_tdata  : a_tdata;

  function automatic logic [31:0] exp_beat(input int hd, input int k);
    logic [15:0] r;
    if (k < 16) r = (16'((hd + k) % 16) << 2) ^ 16'h8000;
    else        r = 16'h0000;
    return {16'h0000, r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit use_b, input int hd, input int pad);
    head     = 4'(hd);
    pad_log2 = 2'(pad);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("first_rd_en", 64'(use_b ? b_rd_en : a_rd_en), 64'(1));
    check("first_addr", 64'(use_b ? b_addr : a_addr), 64'(hd));
    check("busy_after_start", 64'(use_b ? b_busy : a_busy), 64'(1));
  endtask

  // Entered at the negedge of the cycle after start; stop_at >= 0 returns right after beat stop_at is accepted.
  task automatic recv_frame(input bit use_b, input int hd, input int nb, input bit bp,
                            input int stop_at, input bit drop);
    int got, c, first;
    bit hold, pend;
    logic [32:0] held, cur;
    got = 0; c = 1; first = -1; hold = 1'b0; pend = 1'b0; held = '0;
    while (got < nb && c < 600) begin
      if (pend) begin
        check("start_dropped_pulse", 64'(a_drop), 64'(1));
        start_a = 1'b0;
        pend = 1'b0;
      end
      tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cur = {m_last, m_dat};
      if (m_vld && first < 0) begin
        first = c;
        check("first_tvalid_latency", 64'(first), 64'(use_b ? 5 : 3));
      end
      if (hold) check("stable_while_stalled", 64'({m_vld, cur}), 64'({1'b1, held}));
      if (!bp && first > 0) check("no_gap", 64'(m_vld), 64'(1));
      if (m_vld && tready) begin
        check("beat", 64'(cur), 64'({got == nb - 1, exp_beat(hd, got)}));
        if (drop && (got == 3 || got == nb - 1)) begin
          start_a = 1'b1;
          pend = 1'b1;
        end
        got++;
        hold = 1'b0;
        if (got == stop_at + 1) return;
      end else begin
        hold = m_vld;
        held = cur;
      end
      @(negedge clk);
      c++;
    end
    if (pend) begin
      check("start_dropped_final", 64'(a_drop), 64'(1));
      start_a = 1'b0;
    end
    if (stop_at < 0) check("beat_count", 64'(got), 64'(nb));
  endtask

  initial begin
    head = '0; pad_log2 = '0; last_missing = 1'b0; tready = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_tvalid", 64'(a_tvalid), 64'(0));
    check("rst_a_busy", 64'(a_busy), 64'(0));
    check("rst_a_frames", 64'(a_frames), 64'(0));
    check("rst_a_rd_en", 64'(a_rd_en), 64'(0));
    check("rst_a_tdata", 64'(a_tdata), 64'(0));
    check("rst_b_tvalid", 64'(b_tvalid), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame: 16 samples from head 5 then 48 zeros.
    sel_b = 1'b0;
    pulse_start(1'b0, 5, 2);
    recv_frame(1'b0, 5, 64, 1'b0, -1, 1'b0);
    check("basic_busy_done", 64'(a_busy), 64'(0));
    check("basic_tvalid_done", 64'(a_tvalid), 64'(0));
    check("basic_frames", 64'(a_frames), 64'(1));
    check("basic_no_drop", 64'(a_drop), 64'(0));
    repeat (2) @(negedge clk);

    // Random tready back-pressure.
    pulse_start(1'b0, 5, 2);
    recv_frame(1'b0, 5, 64, 1'b1, -1, 1'b0);
    tready = 1'b1;
    check("bp_busy_done", 64'(a_busy), 64'(0));
    check("bp_frames", 64'(a_frames), 64'(2));
    repeat (2) @(negedge clk);

    // Starts at beat 3 and on the final handshake are ignored.
    pulse_start(1'b0, 5, 2);
    recv_frame(1'b0, 5, 64, 1'b0, -1, 1'b1);
    check("drop_frames", 64'(a_frames), 64'(3));
    check("drop_busy_done", 64'(a_busy), 64'(0));
    repeat (3) @(negedge clk);
    check("drop_no_restart", 64'(a_busy), 64'(0));
    check("drop_no_tvalid", 64'(a_tvalid), 64'(0));

    // Abort at beat 7, then a clean frame from a new head.
    pulse_start(1'b0, 9, 1);
    recv_frame(1'b0, 9, 32, 1'b0, 7, 1'b0);
    last_missing = 1'b1;
    @(negedge clk);
    last_missing = 1'b0;
    check("abort_tvalid", 64'(a_tvalid), 64'(0));
    check("abort_busy", 64'(a_busy), 64'(0));
    check("abort_frames", 64'(a_frames), 64'(3));
    repeat (4) @(negedge clk);
    check("abort_quiet", 64'(a_tvalid), 64'(0));
    pulse_start(1'b0, 2, 0);
    recv_frame(1'b0, 2, 16, 1'b0, -1, 1'b0);
    check("post_abort_frames", 64'(a_frames), 64'(4));
    repeat (2) @(negedge clk);

    // Asynchronous reset at beat 20.
    pulse_start(1'b0, 5, 2);
    recv_frame(1'b0, 5, 64, 1'b0, 20, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(a_tvalid), 64'(0));
    check("mid_rst_busy", 64'(a_busy), 64'(0));
    check("mid_rst_rd_en", 64'(a_rd_en), 64'(0));
    check("mid_rst_addr", 64'(a_addr), 64'(0));
    check("mid_rst_tdata", 64'(a_tdata), 64'(0));
    check("mid_rst_tlast", 64'(a_tlast), 64'(0));
    check("mid_rst_frames", 64'(a_frames), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_tvalid", 64'(a_tvalid), 64'(0));
    check("post_rst_busy", 64'(a_busy), 64'(0));

    // pad_log2=3 clamps to 2: 64 beats.
    pulse_start(1'b0, 0, 3);
    recv_frame(1'b0, 0, 64, 1'b0, -1, 1'b0);
    check("clamp_frames", 64'(a_frames), 64'(1));

    // RD_LAT=3, no padding.
    sel_b = 1'b1;
    @(negedge clk);
    pulse_start(1'b1, 3, 0);
    recv_frame(1'b1, 3, 16, 1'b0, -1, 1'b0);
    check("lat3_busy_done", 64'(b_busy), 64'(0));
    check("lat3_frames", 64'(b_frames), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bram_frame_streamer.md
Name: bram_frame_streamer

Overview:
- Parametrised successor to the BRAM-to-FFT frame sender.
- On `start`, reads one full circular sample BRAM, beginning at the current `head`, and converts each sample to signed.
- Streams the frame to the FFT core as an AXI-stream frame, zero-padded to a runtime-selectable multiple of the BRAM depth.
- Handles configurable BRAM read latency and back-pressure correctly: data is held stable while `frame_tready` is low, and no samples are lost or duplicated.

Parameters:
- ADDR_W, 12: BRAM address width; BRAM depth D = 2^ADDR_W.
- DATA_W, 14: BRAM sample width (unsigned offset-binary when OFFSET_BIN=1).
- OUT_W, 16: width of the real and imaginary parts in `frame_tdata`; requires OUT_W >= DATA_W.
- PAD_MAX, 2: maximum legal value of `pad_log2`.
- RD_LAT, 1: BRAM read latency in cycles, from `rd_en`/`addr` to valid `data`; legal range 1..3.
- OFFSET_BIN, 1: 1 = subtract mid-scale (invert MSB); 0 = data already two's complement.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- head  in  ADDR_W  oldest-sample address of the circular buffer
- addr  out  ADDR_W  BRAM read address
- rd_en  out  1  BRAM read enable
- data  in  DATA_W  BRAM read data, valid RD_LAT cycles after `rd_en`
- start  in  1  single-cycle request to send one frame
- pad_log2  in  2  zero-pad factor; frame length N = D << pad_log2
- last_missing  in  1  FFT core event: frame ended early; abort
- frame_tdata  out  2*OUT_W  {imag = 0, real = sample}
- frame_tvalid  out  1  AXI-stream valid
- frame_tready  in  1  AXI-stream ready
- frame_tlast  out  1  high on beat N-1
- busy  out  1  high from accepted start to frame end or abort
- start_dropped  out  1  one-cycle pulse when `start` is ignored
- frames_sent  out  16  count of completed frames, wraps

Behaviour:
- Reset (async, any time including mid-frame):
  - all outputs go to 0; counters and FIFO are cleared; state = IDLE.
  - The first frame after reset release needs a new `start`.
- States:
  - IDLE -> SEND when `start` = 1.
  - SEND -> IDLE on the handshake of the tlast beat, or on `last_missing`.
- On start acceptance:
  - latch `head` into the read pointer;
  - latch `pad_log2` (values > PAD_MAX clamp to PAD_MAX);
  - clear the issue and send counters; set `busy`.
- `start` while `busy`, including the cycle of the final handshake: ignored, `start_dropped` pulses.
- Issue side: one beat per cycle while credit is available.
  - Credit: FIFO occupancy + in-flight beats < FIFO depth, where FIFO depth = RD_LAT + 2.
  - Beats 0..D-1: `rd_en` = 1 with `addr` = read pointer; the pointer increments and wraps modulo D.
  - Beats D..N-1: no read; a zero-tagged token is issued instead.
  - Both kinds traverse the same RD_LAT-stage tag pipeline, so ordering is preserved.
  - `rd_en` = 0 otherwise.
- Conversion (registered into the FIFO):
  - real = {data, (OUT_W-DATA_W) zeros}, with the MSB inverted when OFFSET_BIN = 1.
  - Zero tokens give real = 0. imag is always 0.
- Output side:
  - `frame_tvalid` = FIFO not empty; `frame_tdata`/`frame_tlast` come from the FIFO head.
  - They stay stable while `frame_tvalid` = 1 and `frame_tready` = 0.
  - A pop happens only on `frame_tvalid` & `frame_tready`.
- `frame_tlast` is set only on the entry for beat N-1.
- On the tlast handshake:
  - `frames_sent` += 1;
  - `busy` goes to 0 the next cycle.
- Latency: start sampled at cycle t; first `rd_en` at t+1; first `frame_tvalid` at t+2+RD_LAT.
- Throughput: with `tready` held high, N beats are transferred in consecutive cycles.
- Abort (`last_missing` = 1 while `busy`):
  - next cycle: `frame_tvalid` = 0, FIFO and tag pipeline flushed, late BRAM returns discarded, `busy` = 0;
  - `frames_sent` unchanged.
  - `last_missing` in IDLE has no effect.
- Simultaneous abort and final handshake: the frame counts as sent; the state still ends in IDLE.
- Counter widths: the send counter is ADDR_W+PAD_MAX bits; wrap of the read pointer is legal (`head` need not be 0).

Test Plan:
- Basic frame, ADDR_W=4, DATA_W=14, pad_log2=2, head=5, RD_LAT=1, tready=1, BRAM[i]=i: start -> 64 consecutive beats.
  - First 16 beats read addr 5..15,0..4 with real = (i<<2)^0x8000.
  - Last 48 beats are 0; tlast only on beat 63; frames_sent=1; first tvalid 3 cycles after start.
- Back-pressure: as above, with tready toggling via a random 50% pattern.
  - Received sequence is identical to the basic frame; tdata never changes while tvalid&!tready.
  - FIFO never overflows.
- RD_LAT=3, pad_log2=0, D=16: start -> 16 beats, no zeros, tlast on beat 15; first tvalid 5 cycles after start.
- Abort: last_missing at beat 7 -> tvalid=0 next cycle, busy=0, frames_sent unchanged.
  - A following start gives a clean full frame beginning at the new head.
- Dropped start: start pulsed at beat 3 and in the final-handshake cycle -> two start_dropped pulses; the frame is unaffected.
- Reset mid-frame (rst at beat 20): all outputs 0 immediately (asynchronous); no tvalid until the next start.
  - pad_log2=3 on a later start is clamped to 2 (64 beats).
